// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, controller states and the store byte-merge helper.
package cache_pkg;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int OFFSET_W = 4;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, GAP, FILL, RESP, FL_SCAN, FL_WB} state_t;
  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line, input logic [1:0] wsel,
                                                   input logic [WORD_W-1:0] data, input logic [3:0] be);
    logic [LINE_W-1:0] r;
    r = line;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[wsel*32 + b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/cache_way_ram.sv
// cache_way_ram: one way of tag+data storage, synchronous read, byte-masked line write.
module cache_way_ram
  import cache_pkg::*;
#(
  parameter int INDEX_W = 10,
  parameter int TAG_W = 13
) (
  input  logic                  clk,
  input  logic [INDEX_W-1:0]    rd_idx,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_W-1:0]     rd_line,
  input  logic                  wr_en,
  input  logic [INDEX_W-1:0]    wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [LINE_W-1:0]     wr_line,
  input  logic [LINE_W/8-1:0]   wr_mask
);
  logic [TAG_W-1:0]  tags [2**INDEX_W];
  logic [LINE_W-1:0] data [2**INDEX_W];
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      for (int b = 0; b < LINE_W/8; b++)
        if (wr_mask[b]) data[wr_idx][b*8 +: 8] <= wr_line[b*8 +: 8];
    end
    rd_tag <= tags[rd_idx];
    rd_line <= data[rd_idx];
  end
endmodule

// File: rtl/cache_assoc.sv
// cache_assoc: write-back, write-allocate L1 data cache (1- or 2-way LRU) with full flush,
// sitting between the core load/store unit and the DDR2 line interface.
module cache_assoc
  import cache_pkg::*;
#(
  parameter int ADDR_W = 27,
  parameter int INDEX_W = 10,
  parameter int WAYS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  input  logic              flush,
  output logic              flush_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic              mem_ack,
  input  logic [127:0]      mem_rdata
);
  localparam int SETS = 2**INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
    $error("cache_assoc: WAYS must be 1 or 2");
  end
  state_t state;
  logic [ADDR_W-1:0] addr_q;
  logic we_q;
  logic [31:0] wdata_q;
  logic [3:0] be_q;
  logic [SETS-1:0] valid [WAYS];
  logic [SETS-1:0] dirty [WAYS];
  logic [SETS-1:0] lru;
  logic vway, hway, miss_way, wb_way, scan_way, hit, last, hit_store, ack_fill;
  logic [INDEX_W-1:0] scan_set, idx, rd_idx;
  logic [TAG_W-1:0] tag;
  logic [1:0] wsel;
  logic [WAYS-1:0] hit_vec;
  logic [TAG_W-1:0] rd_tag [WAYS];
  logic [LINE_W-1:0] rd_line [WAYS];
  logic [LINE_W-1:0] wr_line;
  logic [LINE_W/8-1:0] wr_mask;
  assign idx = addr_q[OFFSET_W +: INDEX_W];
  assign tag = addr_q[ADDR_W-1 -: TAG_W];
  assign wsel = addr_q[3:2];
  // Arrays track the incoming request in IDLE so LOOKUP sees the set one cycle later
  assign rd_idx = state == IDLE ? req_addr[OFFSET_W +: INDEX_W]
                : (state == FL_SCAN || state == FL_WB) ? scan_set : idx;
  assign hit = |hit_vec;
  assign hway = WAYS == 2 && hit_vec[WAYS-1];
  assign miss_way = !valid[0][idx] ? 1'b0 : (WAYS == 2 && !valid[WAYS-1][idx]) ? 1'b1 : (WAYS == 2 && lru[idx]);
  assign hit_store = state == LOOKUP && hit && we_q;
  assign ack_fill = state == FILL && mem_ack;
  assign wr_line = ack_fill ? (we_q ? merge_word(mem_rdata, wsel, wdata_q, be_q) : mem_rdata) : {4{wdata_q}};
  assign wr_mask = ack_fill ? '1 : 16'(be_q) << {wsel, 2'b00};
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign hit_vec[w] = valid[w][idx] && rd_tag[w] == tag;
    cache_way_ram #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_ram (
      .clk(clk), .rd_idx(rd_idx), .rd_tag(rd_tag[w]), .rd_line(rd_line[w]),
      .wr_en((hit_store && hway == 1'(w)) || (ack_fill && vway == 1'(w))),
      .wr_idx(idx), .wr_tag(tag), .wr_line(wr_line), .wr_mask(wr_mask)
    );
  end
  assign req_ready = state == IDLE && !flush;
  assign resp_valid = state == RESP;
  assign mem_req = state == WB || state == FILL || state == FL_WB;
  assign mem_we = state == WB || state == FL_WB;
  assign wb_way = state == FL_WB ? scan_way : vway;
  assign mem_addr = state == FILL ? {tag, idx, 4'b0000}
                  : mem_we ? {rd_tag[wb_way], state == FL_WB ? scan_set : idx, 4'b0000} : '0;
  assign mem_wdata = mem_we ? rd_line[wb_way] : '0;
  assign last = scan_set == INDEX_W'(SETS-1) && scan_way == 1'(WAYS-1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= '{default: '0};
      dirty <= '{default: '0};
      lru <= '0;
      flush_done <= 1'b0;
      resp_rdata <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      be_q <= '0;
      vway <= 1'b0;
      scan_set <= '0;
      scan_way <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE: if (flush) begin
          state <= FL_SCAN;
          scan_set <= '0;
          scan_way <= 1'b0;
        end else if (req_valid) begin
          addr_q <= req_addr;
          we_q <= req_we;
          wdata_q <= req_wdata;
          be_q <= req_be;
          state <= LOOKUP;
        end
        LOOKUP: if (hit) begin
          if (we_q) dirty[hway][idx] <= 1'b1;
          else resp_rdata <= rd_line[hway][wsel*32 +: 32];
          if (WAYS == 2) lru[idx] <= !hway;
          state <= RESP;
        end else begin
          vway <= miss_way;
          state <= valid[miss_way][idx] && dirty[miss_way][idx] ? WB : FILL;
        end
        WB: if (mem_ack) state <= GAP;
        GAP: state <= FILL;
        FILL: if (mem_ack) begin
          valid[vway][idx] <= 1'b1;
          dirty[vway][idx] <= we_q;
          if (!we_q) resp_rdata <= mem_rdata[wsel*32 +: 32];
          if (WAYS == 2) lru[idx] <= !vway;
          state <= RESP;
        end
        RESP: state <= IDLE;
        default: if (state == FL_SCAN && valid[scan_way][scan_set] && dirty[scan_way][scan_set]) begin
          state <= FL_WB;
        end else if (state == FL_SCAN || mem_ack) begin
          if (state == FL_WB) dirty[scan_way][scan_set] <= 1'b0;
          if (last) begin
            flush_done <= 1'b1;
            state <= IDLE;
          end else begin
            state <= FL_SCAN;
            scan_way <= WAYS == 2 && !scan_way;
            if (WAYS == 1 || scan_way) scan_set <= scan_set + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_assoc.sv
// tb_cache_assoc: directed scoreboard bench for cache_assoc with a behavioural DDR2 responder.
module tb_cache_assoc;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_we = 0, flush = 0, mem_ack, req_ready, resp_valid, flush_done, mem_req, mem_we;
  logic [26:0] req_addr = '0, mem_addr;
  logic [31:0] req_wdata = '0, resp_rdata;
  logic [3:0] req_be = '0;
  logic [127:0] mem_wdata, mem_rdata;
  always #5 clk = ~clk;

  cache_assoc #(.ADDR_W(27), .INDEX_W(10), .WAYS(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .flush(flush), .flush_done(flush_done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {logic ld; logic [31:0] d;} rexp_t;
  typedef struct {logic we; logic [26:0] a;} mexp_t;
  rexp_t resp_q[$];
  mexp_t mem_q[$];
  logic [127:0] mem [int];
  int checks = 0, errors = 0, cyc = 0;
  int resp_cnt = 0, resp_cyc = 0, acc_cyc = 0, mem_cnt = 0, ack_cyc = 0, wack_cyc = 0, rd_start = 0, done_cnt = 0;
  int m0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] init_line(input logic [26:0] a);
    logic [31:0] b;
    b = 32'h5A00_0000 + 32'(a);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  initial begin : monitor
    rexp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && flush_done) done_cnt++;
      if (rst_n && resp_valid) begin
        resp_cnt++;
        resp_cyc = cyc;
        checks++;
        if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got rdata %0h expected no response", resp_rdata);
        end else begin
          e = resp_q.pop_front();
          if (e.ld && resp_rdata !== e.d) begin
            errors++;
            $display("FAIL resp_rdata: got %0h expected %0h", resp_rdata, e.d);
          end
        end
      end
    end
  end

  initial begin : responder
    mexp_t e;
    logic [26:0] a;
    logic w;
    bit ab;
    mem_ack = 0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 0;
      if (rst_n && mem_req) begin
        mem_cnt++;
        a = mem_addr;
        w = mem_we;
        if (!w) rd_start = cyc;
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_mem_req: got we=%0b addr=%0h expected none", w, a);
        end else begin
          e = mem_q.pop_front();
          if (e.we !== w || e.a !== a) begin
            errors++;
            $display("FAIL mem_txn: got we=%0b addr=%0h expected we=%0b addr=%0h", w, a, e.we, e.a);
          end
        end
        ab = 0;
        repeat (2) begin
          @(negedge clk);
          if (!rst_n) ab = 1;
          else if (!ab) chk("mem_hold", {mem_req, mem_we, mem_addr}, {1'b1, w, a});
        end
        if (!ab && rst_n) begin
          if (w) begin
            mem[int'(a)] = mem_wdata;
            wack_cyc = cyc;
          end else mem_rdata = mem.exists(int'(a)) ? mem[int'(a)] : init_line(a);
          mem_ack = 1;
          ack_cyc = cyc;
          @(negedge clk);
          mem_ack = 0;
          chk("mem_req_drop", mem_req, 0);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [26:0] a, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic access(input logic we, input logic [26:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic [31:0] exp);
    int n = 0, n0;
    resp_q.push_back('{!we, exp});
    n0 = resp_cnt;
    issue(we, a, d, be);
    while (resp_cnt == n0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (resp_cnt == n0) begin
      errors++;
      $display("FAIL resp_timeout: got no resp_valid expected one for addr %0h", a);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [26:0] a);
    mem_q.push_back('{we, a});
  endtask

  task automatic do_flush();
    int n = 0, n0;
    n0 = done_cnt;
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    while (done_cnt == n0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("flush_done_count", 32'(done_cnt - n0), 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int n;
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outputs", {resp_valid, flush_done, mem_req, mem_we, mem_addr, resp_rdata}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    // cold load, word 1 of line 0x10
    exp_mem(0, 27'h10);
    access(0, 27'h14, 0, 0, 32'h5A00_0011);
    chk("fill_resp_latency", 32'(resp_cyc - ack_cyc), 1);
    m0 = mem_cnt;
    access(0, 27'h14, 0, 0, 32'h5A00_0011);
    chk("hit_latency", 32'(resp_cyc - acc_cyc), 2);
    chk("hit_no_mem", 32'(mem_cnt - m0), 0);
    exp_mem(0, 27'h0);
    access(0, 27'h4, 0, 0, 32'h5A00_0001);
    access(1, 27'h4, 32'hDEAD_BEEF, 4'b0011, 0);
    chk("store_hit_latency", 32'(resp_cyc - acc_cyc), 2);
    access(0, 27'h4, 0, 0, 32'h5A00_BEEF);
    // set 3: A dirty, B clean, touch A, C evicts B, D evicts A with writeback
    exp_mem(0, 27'h4030);
    access(1, 27'h4030, 32'h1234_5678, 4'b1111, 0);
    exp_mem(0, 27'h8030);
    access(0, 27'h8030, 0, 0, 32'h5A00_8030);
    m0 = mem_cnt;
    access(0, 27'h4030, 0, 0, 32'h1234_5678);
    chk("hit_A_no_mem", 32'(mem_cnt - m0), 0);
    exp_mem(0, 27'hC030);
    m0 = mem_cnt;
    access(0, 27'hC030, 0, 0, 32'h5A00_C030);
    chk("evict_clean_one_txn", 32'(mem_cnt - m0), 1);
    exp_mem(1, 27'h4030);
    exp_mem(0, 27'h10030);
    access(0, 27'h10030, 0, 0, 32'h5A01_0030);
    chk("gap_cycles", 32'(rd_start - wack_cyc), 2);
    chk("wb_data_A", mem[32'h4030][63:0], 64'h5A00_4031_1234_5678);
    exp_mem(0, 27'h4030);
    access(0, 27'h4030, 0, 0, 32'h1234_5678);
    // dirty sets 5 and 1023 alongside set 0, then flush
    exp_mem(0, 27'h50);
    access(1, 27'h54, 32'hCAFE_F00D, 4'b1111, 0);
    exp_mem(0, 27'h3FF0);
    access(1, 27'h3FF8, 32'h0BAD_C0DE, 4'b1100, 0);
    exp_mem(1, 27'h0);
    exp_mem(1, 27'h50);
    exp_mem(1, 27'h3FF0);
    m0 = mem_cnt;
    do_flush();
    chk("flush_wb_count", 32'(mem_cnt - m0), 3);
    chk("flush_data_0", mem[32'h0][63:32], 32'h5A00_BEEF);
    chk("flush_data_50", mem[32'h50][63:32], 32'hCAFE_F00D);
    chk("flush_data_3ff0", mem[32'h3FF0][95:64], 32'h0BAD_3FF2);
    m0 = mem_cnt;
    access(0, 27'h54, 0, 0, 32'hCAFE_F00D);
    do_flush();
    chk("after_flush_clean", 32'(mem_cnt - m0), 0);
    // reset while a fill is outstanding
    exp_mem(0, 27'h7770);
    issue(0, 27'h7774, 0, 0);
    n = 0;
    while (!mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("fill_started", mem_req, 1);
    @(negedge clk);
    #1 rst_n = 0;
    #1 chk("reset_drops_mem_req", {mem_req, resp_valid, req_ready}, 3'b001);
    repeat (3) @(negedge clk);
    rst_n = 1;
    exp_mem(0, 27'h7770);
    m0 = mem_cnt;
    access(0, 27'h7774, 0, 0, 32'h5A00_7771);
    chk("refill_after_reset", 32'(mem_cnt - m0), 1);
    exp_mem(0, 27'h50);
    access(0, 27'h54, 0, 0, 32'hCAFE_F00D);
    repeat (5) @(negedge clk);
    chk("resp_queue_drained", 32'(resp_q.size()), 0);
    chk("mem_queue_drained", 32'(mem_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
